mdd_arbiter: RTL and testbench

- Two-port arbiter and sequencer in front of the MDD data memory (8-bit address, 8-bit data).
- Port 0 is the CPU data path and has priority. Port 1 is the secondary master (loader/debug).
- Captures one request at a time, drives the MDD control signals for exactly one cycle, then returns read data and a completion pulse to the owner.
- A starvation counter bounds how long port 1 can wait.

---
 rtl/mdd_pkg.sv | 34 +++
 rtl/mdd_arb_pick.sv | 26 ++
 rtl/mdd_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mdd_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdd_pkg.sv
// mdd_pkg: shared widths, sequencer states and owner encoding for the MDD
// data-memory arbiter (mdd_arbiter and its grant picker mdd_arb_pick).
package mdd_pkg;

   // MDD data memory geometry.
   localparam int unsigned MDD_ADDR_W = 8;
   localparam int unsigned MDD_DATA_W = 8;

   // Starvation counter width and its saturation value.
   localparam int unsigned STARVE_W = 4;
   localparam logic [STARVE_W-1:0] STARVE_SAT = 4'hF;

   // Request sequencer states.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } mdd_state_t;

   // Owner encoding: port 0 is the CPU data path, port 1 the loader/debug master.
   localparam logic OWN_P0 = 1'b0;
   localparam logic OWN_P1 = 1'b1;

   // Saturating increment for the starvation counter.
   function automatic logic [STARVE_W-1:0] starve_inc(input logic [STARVE_W-1:0] cnt);
      logic [STARVE_W-1:0] res;
      res = cnt;
      if (cnt != STARVE_SAT) begin
         res = cnt + STARVE_W'(1);
      end
      return res;
   endfunction

endpackage

// File: rtl/mdd_arb_pick.sv
// mdd_arb_pick: combinational grant selection between the two MDD requesters.
// Port 0 wins contention unless port 1 has waited through HOLD_MAX port-0 grants.
module mdd_arb_pick
   import mdd_pkg::*;
#(
   parameter int unsigned HOLD_MAX = 4
) (
   input  logic                valid0,
   input  logic                valid1,
   input  logic [STARVE_W-1:0] starve_cnt,
   output logic                grant,
   output logic                owner
);

   localparam logic [STARVE_W-1:0] HOLD_LIMIT = STARVE_W'(HOLD_MAX);

   // Pick the winner; owner is only meaningful while grant is high.
   always_comb begin
      grant = valid0 | valid1;
      owner = OWN_P0;
      if (valid1 && (!valid0 || (starve_cnt >= HOLD_LIMIT))) begin
         owner = OWN_P1;
      end
   end

endmodule

// File: rtl/mdd_arbiter.sv
// mdd_arbiter: two-port arbiter and sequencer in front of the MDD data memory.
// One request is captured at a time, the memory is strobed for exactly one
// ACCESS cycle, and the owner gets a one-cycle completion pulse in RESP.
// Optional feature macro: MDD_ARB_WPROT_EN (port-1 write protection at and above
// WPROT_BASE; a protected write keeps its ACCESS slot but never strobes the memory).
module mdd_arbiter
   import mdd_pkg::*;
#(
   parameter int unsigned       ADDR_W     = MDD_ADDR_W,
   parameter int unsigned       DATA_W     = MDD_DATA_W,
   parameter int unsigned       HOLD_MAX   = 4,
   parameter logic [ADDR_W-1:0] WPROT_BASE = 8'hF0
) (
   input  logic              clock,
   input  logic              reset,
   // Port 0: CPU data path (priority)
   input  logic              req0_valid,
   input  logic              req0_write,
   input  logic [ADDR_W-1:0] req0_address,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              req0_ready,
   output logic              req0_rvalid,
   output logic [DATA_W-1:0] req0_rdata,
   // Port 1: loader / debug master
   input  logic              req1_valid,
   input  logic              req1_write,
   input  logic [ADDR_W-1:0] req1_address,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              req1_ready,
   output logic              req1_rvalid,
   output logic [DATA_W-1:0] req1_rdata,
   output logic              req1_err,
   // MDD memory side
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_write_data,
   output logic              mem_write,
   output logic              mem_read,
   input  logic [DATA_W-1:0] mem_data
);

   mdd_state_t          state;
   logic                owner;
   logic                lat_write;
   logic [ADDR_W-1:0]   lat_address;
   logic [DATA_W-1:0]   lat_wdata;
   logic [DATA_W-1:0]   rdata;
   logic [STARVE_W-1:0] starve_cnt;

   logic                pick_grant;
   logic                pick_owner;
   logic                sel_write;
   logic [ADDR_W-1:0]   sel_address;
   logic [DATA_W-1:0]   sel_wdata;
   logic [STARVE_W-1:0] starve_next;
   logic                wprot_hit;
   logic                in_access;
   logic                in_resp;

   mdd_arb_pick #(
      .HOLD_MAX (HOLD_MAX)
   ) u_pick (
      .valid0     (req0_valid),
      .valid1     (req1_valid),
      .starve_cnt (starve_cnt),
      .grant      (pick_grant),
      .owner      (pick_owner)
   );

   // Steer the winning requester's fields toward the capture registers.
   always_comb begin
      sel_write   = req0_write;
      sel_address = req0_address;
      sel_wdata   = req0_wdata;
      if (pick_owner == OWN_P1) begin
         sel_write   = req1_write;
         sel_address = req1_address;
         sel_wdata   = req1_wdata;
      end
   end

   // Starvation count after this grant: grow only while port 0 passes over a waiting port 1.
   always_comb begin
      starve_next = '0;
      if ((pick_owner == OWN_P0) && req1_valid) begin
         starve_next = starve_inc(starve_cnt);
      end
   end

`ifdef MDD_ARB_WPROT_EN
   // Protected port-1 write, judged on the latched request.
   always_comb begin
      wprot_hit = (owner == OWN_P1) && lat_write && (lat_address >= WPROT_BASE);
   end
`else
   logic unused_wprot_base;

   // No write protection in this build.
   always_comb begin
      wprot_hit         = 1'b0;
      unused_wprot_base = ^WPROT_BASE;
   end
`endif

   // Sequencer: arbitrate in IDLE/RESP, one memory cycle in ACCESS, report in RESP.
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= ST_IDLE;
         owner       <= OWN_P0;
         lat_write   <= 1'b0;
         lat_address <= '0;
         lat_wdata   <= '0;
         rdata       <= '0;
         starve_cnt  <= '0;
      end else begin
         unique case (state)
            ST_IDLE, ST_RESP: begin
               if (pick_grant) begin
                  state       <= ST_ACCESS;
                  owner       <= pick_owner;
                  lat_write   <= sel_write;
                  lat_address <= sel_address;
                  lat_wdata   <= sel_wdata;
                  starve_cnt  <= starve_next;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_ACCESS: begin
               // Writes (including protected ones) leave rdata untouched.
               if (!lat_write) begin
                  rdata <= mem_data;
               end
               state <= ST_RESP;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Output decode from registered state; memory strobes are masked while reset is high.
   always_comb begin
      in_access      = (state == ST_ACCESS);
      in_resp        = (state == ST_RESP);

      mem_address    = in_access ? lat_address : '0;
      mem_write_data = in_access ? lat_wdata   : '0;
      mem_write      = in_access & lat_write & ~wprot_hit & ~reset;
      mem_read       = in_access & ~lat_write & ~reset;

      req0_ready     = in_access & (owner == OWN_P0);
      req1_ready     = in_access & (owner == OWN_P1);
      req0_rvalid    = in_resp & (owner == OWN_P0);
      req1_rvalid    = in_resp & (owner == OWN_P1);
      req0_rdata     = req0_rvalid ? rdata : '0;
      req1_rdata     = req1_rvalid ? rdata : '0;
      req1_err       = req1_rvalid & wprot_hit;
   end

endmodule

// File: tb/tb_mdd_arbiter.sv
// tb_mdd_arbiter: table-driven and sequence checks for mdd_arbiter, with a
// behavioural MDD memory and a response scoreboard.
module tb_mdd_arbiter;

`ifdef MDD_ARB_WPROT_EN
   localparam bit WPROT = 1'b1;
`else
   localparam bit WPROT = 1'b0;
`endif

   typedef struct {
      bit         port;
      bit         wr;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [7:0] rdata;
      bit         err;
   } vec_t;

   typedef struct {
      bit         port;
      bit         wr;
      logic [7:0] rdata;
      bit         err;
   } sb_t;

   logic       clock;
   logic       reset;
   logic       req0_valid, req0_write, req0_ready, req0_rvalid;
   logic [7:0] req0_address, req0_wdata, req0_rdata;
   logic       req1_valid, req1_write, req1_ready, req1_rvalid, req1_err;
   logic [7:0] req1_address, req1_wdata, req1_rdata;
   logic [7:0] mem_address, mem_write_data, mem_data;
   logic       mem_write, mem_read;

   int   checks = 0;
   int   errors = 0;
   bit   mon_en = 1'b0;
   sb_t  sb[$];
   vec_t tbl[$];
   int   lat0, lat1;

   logic [7:0] mdd_mem [256];
   bit         mem_ready = 1'b0;

   mdd_arbiter #(
      .ADDR_W     (8),
      .DATA_W     (8),
      .HOLD_MAX   (4),
      .WPROT_BASE (8'hF0)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .req0_valid     (req0_valid),
      .req0_write     (req0_write),
      .req0_address   (req0_address),
      .req0_wdata     (req0_wdata),
      .req0_ready     (req0_ready),
      .req0_rvalid    (req0_rvalid),
      .req0_rdata     (req0_rdata),
      .req1_valid     (req1_valid),
      .req1_write     (req1_write),
      .req1_address   (req1_address),
      .req1_wdata     (req1_wdata),
      .req1_ready     (req1_ready),
      .req1_rvalid    (req1_rvalid),
      .req1_rdata     (req1_rdata),
      .req1_err       (req1_err),
      .mem_address    (mem_address),
      .mem_write_data (mem_write_data),
      .mem_write      (mem_write),
      .mem_read       (mem_read),
      .mem_data       (mem_data)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // MDD model: contents start as ~address, writes land on the rising edge.
   always @(posedge clock) begin
      if (!mem_ready) begin
         for (int i = 0; i < 256; i++) mdd_mem[i] <= 8'(~i);
         mem_ready <= 1'b1;
      end else if (mem_write) begin
         mdd_mem[mem_address] <= mem_write_data;
      end
   end
   assign mem_data = mdd_mem[mem_address];

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   function automatic vec_t mk(input bit p, input bit w, input logic [7:0] a,
                               input logic [7:0] d, input logic [7:0] r, input bit e);
      vec_t v;
      v.port = p; v.wr = w; v.addr = a; v.wdata = d; v.rdata = r; v.err = e;
      return v;
   endfunction

   function automatic sb_t to_sb(input vec_t v);
      sb_t e;
      e.port = v.port; e.wr = v.wr; e.rdata = v.rdata; e.err = v.err;
      return e;
   endfunction

   task automatic drive(input bit p, input bit v, input bit w, input logic [7:0] a,
                        input logic [7:0] d);
      if (p) begin
         req1_valid = v; req1_write = w; req1_address = a; req1_wdata = d;
      end else begin
         req0_valid = v; req0_write = w; req0_address = a; req0_wdata = d;
      end
   endtask

   task automatic check_all_zero(input string name);
      chk(name, {req0_ready, req0_rvalid, req0_rdata, req1_ready, req1_rvalid, req1_rdata,
                 req1_err, mem_address, mem_write_data, mem_write, mem_read}, 64'd0);
   endtask

   // Raise one request, wait for its ready, check the ACCESS strobes, drop valid.
   task automatic port_req(input vec_t v, output int lat);
      bit blocked;
      blocked = WPROT && v.port && v.wr && (v.addr >= 8'hF0);
      lat = -1;
      drive(v.port, 1'b1, v.wr, v.addr, v.wdata);
      for (int c = 0; c < 40; c++) begin
         @(negedge clock);
         if ((v.port ? req1_ready : req0_ready) === 1'b1) begin
            lat = c;
            chk("acc_mem_write", mem_write, v.wr && !blocked);
            chk("acc_mem_read", mem_read, !v.wr);
            chk("acc_mem_address", mem_address, v.addr);
            if (v.wr) chk("acc_mem_wdata", mem_write_data, v.wdata);
            break;
         end
      end
      if (lat < 0) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout: port %0d got no ready within 40 cycles, expected one", v.port);
      end
      @(posedge clock);
      #1;
      drive(v.port, 1'b0, 1'b0, 8'h00, 8'h00);
   endtask

   // Single transaction from IDLE: ready in the cycle after valid rises.
   task automatic txn(input vec_t v);
      int lat;
      sb.push_back(to_sb(v));
      port_req(v, lat);
      chk("ready_latency", lat, 1);
      @(posedge clock);
      #1;
   endtask

   // Response scoreboard and per-cycle bus invariants.
   initial begin : monitor
      sb_t        e;
      logic       prev0, prev1;
      logic [7:0] last_rdata;
      logic [7:0] act;
      prev0 = 1'b0; prev1 = 1'b0; last_rdata = 8'h00;
      forever begin
         @(negedge clock);
         if (reset) begin
            prev0 = 1'b0; prev1 = 1'b0; last_rdata = 8'h00;
         end else if (mon_en) begin
            chk("ready_exclusive", req0_ready & req1_ready, 0);
            chk("rvalid_exclusive", req0_rvalid & req1_rvalid, 0);
            chk("rvalid0_follows_ready", req0_rvalid, prev0);
            chk("rvalid1_follows_ready", req1_rvalid, prev1);
            if (!(req0_ready | req1_ready))
               chk("mem_quiet_outside_access",
                   {mem_read, mem_write, mem_address, mem_write_data}, 0);
            if (req0_rvalid | req1_rvalid) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_rvalid: got rvalid0=%b rvalid1=%b, expected none",
                           req0_rvalid, req1_rvalid);
               end else begin
                  e = sb.pop_front();
                  chk("rsp_port", {req1_rvalid, req0_rvalid}, e.port ? 2'b10 : 2'b01);
                  act = e.port ? req1_rdata : req0_rdata;
                  chk("rsp_rdata", act, e.wr ? last_rdata : e.rdata);
                  chk("rsp_err", req1_err, e.port ? e.err : 1'b0);
                  if (!e.wr) last_rdata = e.rdata;
               end
            end else begin
               chk("err_without_rvalid", req1_err, 0);
            end
            prev0 = req0_ready;
            prev1 = req1_ready;
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1);
   end

   initial begin : stim
      logic [7:0] bb_addr [3];
      logic [7:0] bb_data [3];
      int         n0, lat;
      bit         got0, got1;

      // Stimulus table: {port, write, address, wdata, expected rdata, expected err}.
      tbl.push_back(mk(0, 1, 8'h01, 8'h05, 8'h00, 0));
      tbl.push_back(mk(0, 0, 8'h01, 8'h00, 8'h05, 0));
      tbl.push_back(mk(1, 1, 8'h30, 8'h3C, 8'h00, 0));
      tbl.push_back(mk(1, 0, 8'h30, 8'h00, 8'h3C, 0));
      tbl.push_back(mk(0, 0, 8'h30, 8'h00, 8'h3C, 0));
      tbl.push_back(mk(1, 0, 8'h01, 8'h00, 8'h05, 0));
      tbl.push_back(mk(0, 0, 8'h80, 8'h00, 8'h7F, 0));
      tbl.push_back(mk(1, 0, 8'h10, 8'h00, 8'hEF, 0));
      tbl.push_back(mk(0, 1, 8'h01, 8'hA5, 8'h00, 0));
      tbl.push_back(mk(1, 0, 8'h01, 8'h00, 8'hA5, 0));
      tbl.push_back(mk(1, 1, 8'hEF, 8'h12, 8'h00, 0));
      tbl.push_back(mk(0, 0, 8'hEF, 8'h00, 8'h12, 0));
      tbl.push_back(mk(1, 1, 8'hF2, 8'h77, 8'h00, WPROT));
      tbl.push_back(mk(0, 0, 8'hF2, 8'h00, WPROT ? 8'h0D : 8'h77, 0));
      tbl.push_back(mk(1, 0, 8'hF2, 8'h00, WPROT ? 8'h0D : 8'h77, 0));
      tbl.push_back(mk(0, 1, 8'hF3, 8'h99, 8'h00, 0));
      tbl.push_back(mk(1, 0, 8'hF3, 8'h00, 8'h99, 0));

      bb_addr[0] = 8'h20; bb_addr[1] = 8'h21; bb_addr[2] = 8'h22;
      bb_data[0] = 8'h11; bb_data[1] = 8'h22; bb_data[2] = 8'h33;

      reset = 1'b1;
      drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
      drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      check_all_zero("reset_state_outputs");
      mon_en = 1'b1;
      @(posedge clock);
      #1;

      for (int i = 0; i < tbl.size(); i++) txn(tbl[i]);

      // Simultaneous reads: port 0 first, port 1 in the very next slot.
      sb.push_back(to_sb(mk(0, 0, 8'h80, 8'h00, 8'h7F, 0)));
      sb.push_back(to_sb(mk(1, 0, 8'h01, 8'h00, 8'hA5, 0)));
      fork
         port_req(mk(0, 0, 8'h80, 8'h00, 8'h7F, 0), lat0);
         port_req(mk(1, 0, 8'h01, 8'h00, 8'hA5, 0), lat1);
      join
      chk("simul_p0_latency", lat0, 1);
      chk("simul_p1_latency", lat1, 3);
      @(posedge clock);
      #1;

      // Starvation: four port-0 grants, then port 1, then port 0 resumes.
      for (int i = 0; i < 4; i++) sb.push_back(to_sb(mk(0, 0, 8'h01, 8'h00, 8'hA5, 0)));
      sb.push_back(to_sb(mk(1, 0, 8'h30, 8'h00, 8'h3C, 0)));
      sb.push_back(to_sb(mk(0, 0, 8'h01, 8'h00, 8'hA5, 0)));
      drive(0, 1'b1, 1'b0, 8'h01, 8'h00);
      drive(1, 1'b1, 1'b0, 8'h30, 8'h00);
      n0 = 0;
      got1 = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clock);
         if (req0_ready) n0++;
         if (req1_ready) begin
            got1 = 1'b1;
            break;
         end
      end
      chk("starve_p1_granted", got1, 1);
      chk("starve_p0_grant_count", n0, 4);
      @(posedge clock);
      #1;
      drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
      chk("starve_cnt_cleared", dut.starve_cnt, 0);
      got0 = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clock);
         if (req0_ready) begin
            got0 = 1'b1;
            break;
         end
      end
      chk("starve_p0_resumes", got0, 1);
      @(posedge clock);
      #1;
      drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
      @(posedge clock);
      #1;

      // Back-to-back port-0 writes with valid held: no IDLE cycle between them.
      for (int i = 0; i < 3; i++) sb.push_back(to_sb(mk(0, 1, bb_addr[i], bb_data[i], 8'h00, 0)));
      for (int i = 0; i < 3; i++) begin
         drive(0, 1'b1, 1'b1, bb_addr[i], bb_data[i]);
         lat = -1;
         for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (req0_ready) begin
               lat = c;
               chk("b2b_mem_address", mem_address, bb_addr[i]);
               chk("b2b_mem_write", mem_write, 1);
               break;
            end
         end
         chk("b2b_ready_spacing", lat, 1);
         @(posedge clock);
         #1;
      end
      drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
      @(posedge clock);
      #1;
      for (int i = 0; i < 3; i++) txn(mk(1, 0, bb_addr[i], 8'h00, bb_data[i], 0));

      // Reset during ACCESS of a port-1 write: dropped, no strobe, no response.
      drive(1, 1'b1, 1'b1, 8'h10, 8'hAA);
      @(posedge clock);
      #1;
      chk("rst_mid_in_access", req1_ready, 1);
      reset = 1'b1;
      @(negedge clock);
      chk("rst_mid_strobe_masked", {mem_write, mem_read}, 0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
      @(negedge clock);
      check_all_zero("rst_mid_outputs");
      @(posedge clock);
      #1;
      txn(mk(0, 0, 8'h10, 8'h00, 8'hEF, 0));

      repeat (3) @(posedge clock);
      chk("scoreboard_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
